updown_counter_param: RTL and testbench
=======================================

# updown_counter_param

Parametrised, fully synchronous up/down counter with a programmable modulus, parallel load, wrap or saturate boundary handling, and terminal-count/overflow flags. It is the general-purpose successor to the fixed 4-bit up/down counter. It drives event counters, timers and divider chains, and its `tc` pulse can cascade into a further instance's `en`. All state changes on the rising edge of `clk`; there are no derived or ripple clocks.

## Interface
- `WIDTH`, default 4: counter width in bits, ≥ 2.
- `MAX_VAL`, default 2**WIDTH-1: top of count range (counts 0..MAX_VAL); 1 ≤ MAX_VAL ≤ 2**WIDTH-1.
- `RST_VAL`, default 0: count value after reset; must be ≤ MAX_VAL.
- `PRESCALE`, default 4: enabled cycles per step, ≥ 1. Exists only when `UDC_PRESCALE_EN` is defined.

Ports (name, direction, width, meaning):
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `en` in 1: count enable.
- `up_down` in 1: direction, 1 = up, 0 = down; sampled on every step.
- `sat` in 1: boundary mode, 1 = saturate, 0 = wrap.
- `load` in 1: parallel load strobe.
- `load_val` in WIDTH: value to load.
- `count` out WIDTH: registered count.
- `tc` out 1: registered one-cycle terminal-count pulse.
- `at_max` out 1: `count == MAX_VAL`, decoded from the register.
- `at_zero` out 1: `count == 0`, decoded from the register.
- `ovf` out 1: sticky boundary flag.

## Operation
- Per-edge priority: `rst` > `load` > step > hold.
- `rst`: `count`=RST_VAL, `tc`=0, `ovf`=0, prescaler=0.
- `load`:
  - `count` = min(`load_val`, MAX_VAL); out-of-range values clamp to MAX_VAL.
  - `tc`=0, `ovf`=0, prescaler=0.
  - `en` is ignored in that cycle.
- Step condition: `en` && `tick`. Without the macro, `tick`=1.
- Step, up:
  - `count` < MAX_VAL: `count`+1.
  - `count` == MAX_VAL, `sat`=0: wrap to 0, boundary event.
  - `count` == MAX_VAL, `sat`=1: hold, boundary event.
- Step, down:
  - `count` > 0: `count`-1.
  - `count` == 0, `sat`=0: wrap to MAX_VAL, boundary event.
  - `count` == 0, `sat`=1: hold, boundary event.
- Boundary event: `tc`=1 for the next cycle and `ovf` sets. `ovf` clears only on `rst` or `load`.
- `tc`=0 on any edge without a boundary event.
- `up_down` and `sat` may change on any cycle and take effect at the next step. No state retains the previous direction.
- Arithmetic is done in WIDTH bits. Range checks compare against MAX_VAL, not 2**WIDTH-1.

## Timing
- Step latency: 1 cycle. `count` updates on the edge where `en` (and `tick`) is sampled high.
- `tc` and `ovf` assert on the same edge that commits the boundary update. `tc` is coincident with the wrapped or held `count`.
- `at_max` and `at_zero` are combinational from `count`, with no extra latency.
- Reset values: `count`=RST_VAL, `tc`=0, `ovf`=0, `at_max`=(RST_VAL==MAX_VAL), `at_zero`=(RST_VAL==0).
- `rst` or `load` asserted mid-count overrides a simultaneous step and any pending prescaler tick.
- Back-to-back boundary events (saturate mode with `en` held) keep `tc` high every step cycle.

## Configuration
- `UDC_PRESCALE_EN` defined:
  - A prescaler 0..PRESCALE-1 advances only while `en`=1 and holds while `en`=0.
  - `tick` = `en` && prescaler==PRESCALE-1; the prescaler then returns to 0.
  - One step occurs every PRESCALE enabled cycles.
  - `rst` and `load` zero the prescaler.
- `UDC_PRESCALE_EN` undefined: no prescaler logic and no `PRESCALE` parameter; every enabled cycle steps.

## Test plan
Configuration for all scenarios: WIDTH=4, MAX_VAL=9, RST_VAL=0, macro undefined unless stated.
1. Wrap up: `rst`, then `en`=1, `up_down`=1, `sat`=0 for 12 cycles -> `count` 1..9, 0, 1, 2; `tc`=1 only in the cycle `count`=0; `ovf`=1 from then on.
2. Wrap down: `load_val`=0 loaded, then `up_down`=0, `sat`=0, one step -> `count`=9, `tc`=1, `at_max`=1.
3. Saturate: `load` 8, then `up_down`=1, `sat`=1 for 3 steps -> `count` 9, 9, 9; `tc` = 0, 1, 1.
4. Load clamp and priority: `load_val`=14 with `load`=1 and `en`=1 together -> `count`=9, `tc`=0, `ovf`=0; next, `rst`=1 with `load`=1 -> `count`=0.
5. Direction flip: `count`=5, `up_down` toggled every cycle with `en`=1 -> `count` 6, 5, 6, 5; `tc` stays 0.
6. Prescaler (macro defined, PRESCALE=4): `en`=1 for 8 cycles from reset -> `count` changes only on cycles 4 and 8 (1, then 2); dropping `en` for 2 cycles mid-period delays the next step by 2 cycles.

Source files
------------

// File: rtl/updown_counter_param.sv
// updown_counter_param: modulus up/down counter with load, wrap/saturate, tc/ovf flags; optional prescaler via UDC_PRESCALE_EN
module updown_counter_param #(
  parameter int WIDTH = 4,
  parameter int MAX_VAL = 2**WIDTH-1,
  parameter int RST_VAL = 0
`ifdef UDC_PRESCALE_EN
  , parameter int PRESCALE = 4
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_down,
  input  logic             sat,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             at_max,
  output logic             at_zero,
  output logic             ovf
);
  localparam logic [WIDTH-1:0] MAX = MAX_VAL[WIDTH-1:0];
  localparam logic [WIDTH-1:0] RST = RST_VAL[WIDTH-1:0];
  logic tick, step, bnd;
  logic [WIDTH-1:0] nxt;
`ifdef UDC_PRESCALE_EN
  localparam int PW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PLAST = PW'(PRESCALE-1);
  logic [PW-1:0] pre;
  assign tick = en && pre == PLAST;
  always_ff @(posedge clk)
    if (rst || load) pre <= '0;
    else if (en) pre <= pre == PLAST ? '0 : pre + PW'(1);
`else
  assign tick = 1'b1;
`endif
  assign at_max = count == MAX;
  assign at_zero = count == '0;
  always_comb begin
    step = en && tick;
    bnd = step && (up_down ? at_max : at_zero);
    nxt = bnd ? (sat ? count : (up_down ? '0 : MAX))
              : (up_down ? count + WIDTH'(1) : count - WIDTH'(1));
  end
  always_ff @(posedge clk)
    if (rst) begin
      count <= RST;
      tc <= 1'b0;
      ovf <= 1'b0;
    end else if (load) begin
      count <= load_val > MAX ? MAX : load_val;
      tc <= 1'b0;
      ovf <= 1'b0;
    end else begin
      tc <= bnd;
      ovf <= ovf | bnd;
      if (step) count <= nxt;
    end
endmodule

// File: tb/tb_updown_counter_param.sv
// tb_updown_counter_param: directed plus random checks against an integer reference model (WIDTH=4, MAX_VAL=9)
module tb_updown_counter_param;
  localparam int MX = 9;
`ifdef UDC_PRESCALE_EN
  localparam int PS = 4;
`else
  localparam int PS = 1;
`endif
  logic clk = 0, rst = 0, en = 0, up_down = 0, sat = 0, load = 0;
  logic [3:0] load_val = 0, count;
  logic tc, at_max, at_zero, ovf;
  int checks = 0, errors = 0;
  int m_count = 0, m_tc = 0, m_ovf = 0, m_pre = 0;
  updown_counter_param #(.WIDTH(4), .MAX_VAL(MX), .RST_VAL(0)
`ifdef UDC_PRESCALE_EN
    , .PRESCALE(PS)
`endif
  ) dut (.clk(clk), .rst(rst), .en(en), .up_down(up_down), .sat(sat), .load(load),
         .load_val(load_val), .count(count), .tc(tc), .at_max(at_max), .at_zero(at_zero), .ovf(ovf));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic cyc(input logic r, input logic l, input logic e, input logic ud, input logic s, input int lv);
    @(negedge clk);
    rst = r; load = l; en = e; up_down = ud; sat = s; load_val = lv[3:0];
    @(posedge clk);
    if (r) begin
      m_count = 0; m_tc = 0; m_ovf = 0; m_pre = 0;
    end else if (l) begin
      m_count = lv > MX ? MX : lv; m_tc = 0; m_ovf = 0; m_pre = 0;
    end else begin
      m_tc = 0;
      if (e) begin
        m_pre++;
        if (m_pre == PS) begin
          m_pre = 0;
          if (ud && m_count < MX) m_count++;
          else if (!ud && m_count > 0) m_count--;
          else begin
            m_tc = 1; m_ovf = 1;
            if (!s) m_count = ud ? 0 : MX;
          end
        end
      end
    end
    #1;
    chk("count", count, m_count);
    chk("tc", tc, m_tc);
    chk("ovf", ovf, m_ovf);
    chk("at_max", at_max, m_count == MX);
    chk("at_zero", at_zero, m_count == 0);
  endtask
  initial begin
    cyc(1, 0, 0, 1, 0, 0);
    chk("reset_count", count, 0);
    for (int i = 0; i < 12; i++) begin
      cyc(0, 0, 1, 1, 0, 0);
`ifndef UDC_PRESCALE_EN
      chk("wrap_up_count", count, (i + 1) % 10);
      chk("wrap_up_tc", tc, i == 9);
`endif
    end
    cyc(0, 1, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0);
`ifndef UDC_PRESCALE_EN
    chk("wrap_down_count", count, 9);
    chk("wrap_down_tc", tc, 1);
`endif
    cyc(0, 1, 0, 1, 1, 8);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 1, 1, 1, 0);
`ifndef UDC_PRESCALE_EN
      chk("sat_count", count, 9);
      chk("sat_tc", tc, i > 0);
`endif
    end
    cyc(0, 1, 1, 1, 0, 14);
    chk("clamp_count", count, 9);
    chk("clamp_ovf", ovf, 0);
    cyc(1, 1, 1, 1, 0, 7);
    chk("rst_over_load", count, 0);
    cyc(0, 1, 0, 1, 0, 5);
    for (int i = 0; i < 4; i++) cyc(0, 0, 1, i % 2 == 0, 0, 0);
`ifdef UDC_PRESCALE_EN
    cyc(1, 0, 0, 1, 0, 0);
    for (int i = 1; i <= 8; i++) begin
      cyc(0, 0, 1, 1, 0, 0);
      chk("prescale_count", count, i / 4);
    end
    cyc(0, 0, 1, 1, 0, 0);
    cyc(0, 0, 0, 1, 0, 0);
    cyc(0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 1, 1, 0, 0);
    chk("prescale_delay", count, 3);
`endif
    for (int i = 0; i < 600; i++)
      cyc($urandom_range(15) == 0, $urandom_range(7) == 0, $urandom_range(3) != 0,
          1'($urandom), 1'($urandom), int'($urandom_range(15)));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
